// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between the fetch stage (read-only) and the
// MEM stage (load/store with byte enables). Only one transaction is in flight
// at a time. Data requests win by default, and a streak counter forces a fetch
// grant after STARVE_LIMIT consecutive data grants while a fetch is waiting.
//
// Ports
//   clk, reset                  clock (rising edge), async active-low reset
//   if_req/if_addr              fetch request; held until if_gnt
//   if_gnt, if_rvalid, if_rdata fetch grant pulse, response pulse, held data
//   dm_req/we/be/addr/wdata     data request; held until dm_gnt
//   dm_gnt, dm_rvalid, dm_rdata data grant pulse, response pulse, held data
//   mem_req/we/be/addr/wdata    registered memory request fields
//   mem_ready                   memory accepts the request this cycle
//   mem_rvalid, mem_rdata       memory read response
//   busy                        a transaction is in progress
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,  // legal range 1..15
    parameter int unsigned AW           = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [3:0]    dm_be,
    input  logic [AW-1:0] dm_addr,
    input  logic [31:0]   dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [31:0]   dm_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ready,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t        state_q;
    owner_t        owner_q;
    logic [3:0]    streak_q, streak_d;
    logic          mem_req_q, mem_we_q;
    logic [3:0]    mem_be_q;
    logic [AW-1:0] mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic          if_rvalid_q, dm_rvalid_q;
    logic [31:0]   if_rdata_q, dm_rdata_q;
    logic          data_wins, fetch_wins;

    // Data wins unless a fetch has waited through STARVE_LIMIT data grants.
    assign data_wins  = dm_req & ~(if_req & (streak_q == LIMIT));
    assign fetch_wins = if_req & ~data_wins;

    // Grants are combinational so the requester sees them in the IDLE cycle.
    assign dm_gnt = (state_q == IDLE) & data_wins;
    assign if_gnt = (state_q == IDLE) & fetch_wins;

    always_comb begin
        // NOTE: default first so every path assigns streak_d and no latch is inferred.
        streak_d = streak_q;
        if (dm_gnt) begin
            if (!if_req)               streak_d = 4'd0;
            else if (streak_q < LIMIT) streak_d = streak_q + 4'd1;
        end else if (if_gnt) begin
            streak_d = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q     <= IDLE;
            owner_q     <= OWN_FETCH;
            streak_q    <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= 32'd0;
            dm_rdata_q  <= 32'd0;
        end else begin
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    streak_q <= streak_d;
                    if (dm_gnt) begin
                        owner_q     <= OWN_DATA;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dm_we;
                        mem_be_q    <= dm_be;
                        mem_addr_q  <= dm_addr;
                        mem_wdata_q <= dm_wdata;
                        state_q     <= REQ;
                    end else if (if_gnt) begin
                        owner_q     <= OWN_FETCH;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= 4'b1111;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= 32'd0;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        if (mem_we_q) begin
                            // Stores complete on acceptance; only data can write.
                            dm_rvalid_q <= 1'b1;
                            dm_rdata_q  <= 32'd0;
                            state_q     <= IDLE;
                        end else begin
                            state_q <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (mem_rvalid) begin
                        if (owner_q == OWN_DATA) begin
                            dm_rdata_q  <= mem_rdata;
                            dm_rvalid_q <= 1'b1;
                        end else begin
                            if_rdata_q  <= mem_rdata;
                            if_rvalid_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rvalid = dm_rvalid_q;
    assign dm_rdata  = dm_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single fetch latency, delayed-ready
// store, fetch starvation bound, per-owner read data, reset mid-transaction
// and spurious memory responses. Inputs change 1 time unit after a rising
// edge; outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_rvalid;
    logic [31:0]   if_rdata;
    logic          dm_req, dm_we;
    logic [3:0]    dm_be;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wdata;
    logic          dm_gnt, dm_rvalid;
    logic [31:0]   dm_rdata;
    logic          mem_req, mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready, mem_rvalid;
    logic [31:0]   mem_rdata;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    // Bookkeeping for the auto-responding memory loop.
    logic          hold_if, hold_dm;
    int            n_gnt, n_if_rv, n_dm_rv, n_dual;
    logic [9:0]    gseq;
    logic [31:0]   if_rdata_at_dm_rv, dm_rdata_at_if_rv;

    mem_port_arbiter #(.STARVE_LIMIT(4), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
        .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_val(input logic [AW-1:0] a);
        if (a == 32'h300)      return 32'h12345678;
        else if (a == 32'h400) return 32'hAAAA5555;
        else                   return a ^ 32'hA5A5_0000;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        if_req = 0; if_addr = '0;
        dm_req = 0; dm_we = 0; dm_be = 0; dm_addr = '0; dm_wdata = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        hold_if = 0; hold_dm = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Memory always ready; each accepted read returns mem_val(addr) one cycle
    // later. Requests not held are dropped the cycle after their grant.
    task automatic run_auto(input int cycles);
        logic          pend = 1'b0;
        logic [AW-1:0] pend_addr = '0;
        logic          if_g = 1'b0, dm_g = 1'b0;
        n_gnt = 0; n_if_rv = 0; n_dm_rv = 0; n_dual = 0; gseq = '0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if_g = if_gnt;
            dm_g = dm_gnt;
            if (if_g && dm_g) n_dual++;
            if (if_g || dm_g) begin
                if (n_gnt < 10) gseq[n_gnt] = if_g;
                n_gnt++;
            end
            if (if_rvalid) begin n_if_rv++; dm_rdata_at_if_rv = dm_rdata; end
            if (dm_rvalid) begin n_dm_rv++; if_rdata_at_dm_rv = if_rdata; end
            tick();
            mem_rvalid = pend;
            mem_rdata  = pend ? mem_val(pend_addr) : 32'd0;
            pend       = mem_req && mem_ready && !mem_we;
            pend_addr  = mem_addr;
            if (if_g && !hold_if) if_req = 1'b0;
            if (dm_g && !hold_dm) dm_req = 1'b0;
        end
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
    endtask

    initial begin
        do_reset();
        #1;
        check("rst_busy",    busy,      0);
        check("rst_mem_req", mem_req,   0);
        check("rst_mem_be",  mem_be,    0);
        check("rst_if_rd",   if_rdata,  0);
        check("rst_dm_rd",   dm_rdata,  0);

        // Single fetch, zero-wait memory.
        tick(); if_req = 1; if_addr = 32'h100; mem_ready = 1;
        @(negedge clk);
        check("f_if_gnt@0", if_gnt, 1);
        check("f_dm_gnt@0", dm_gnt, 0);
        check("f_memreq@0", mem_req, 0);
        tick(); if_req = 0;
        @(negedge clk);
        check("f_memreq@1", mem_req, 1);
        check("f_be@1",     mem_be, 4'b1111);
        check("f_we@1",     mem_we, 0);
        check("f_addr@1",   mem_addr, 32'h100);
        tick(); mem_rvalid = 1; mem_rdata = 32'h00500093;
        @(negedge clk);
        check("f_memreq@2", mem_req, 0);
        check("f_ifrv@2",   if_rvalid, 0);
        tick(); mem_rvalid = 0; mem_rdata = 0;
        @(negedge clk);
        check("f_ifrv@3",   if_rvalid, 1);
        check("f_ifrd@3",   if_rdata, 32'h00500093);
        check("f_busy@3",   busy, 0);
        tick();
        @(negedge clk);
        check("f_ifrv@4",   if_rvalid, 0);

        // Store with mem_ready held low for 3 request cycles.
        tick(); dm_req = 1; dm_we = 1; dm_be = 4'b0011; dm_addr = 32'h200;
        dm_wdata = 32'hDEADBEEF; mem_ready = 0;
        @(negedge clk);
        check("s_dm_gnt", dm_gnt, 1);
        tick(); dm_req = 0; dm_we = 0; dm_be = 0; dm_addr = 0; dm_wdata = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("s_hold_req",   mem_req, 1);
            check("s_hold_we",    mem_we, 1);
            check("s_hold_be",    mem_be, 4'b0011);
            check("s_hold_addr",  mem_addr, 32'h200);
            check("s_hold_wdata", mem_wdata, 32'hDEADBEEF);
            check("s_no_rv",      dm_rvalid, 0);
            tick();
        end
        mem_ready = 1;
        @(negedge clk);
        check("s_accept_req", mem_req, 1);
        tick();
        @(negedge clk);
        check("s_dm_rv",   dm_rvalid, 1);
        check("s_dm_rd",   dm_rdata, 0);
        check("s_memreq",  mem_req, 0);
        check("s_busy",    busy, 0);

        // Load 0x300 and fetch 0x400 requested together: data first, then fetch.
        tick(); dm_req = 1; dm_we = 0; dm_be = 4'b1111; dm_addr = 32'h300;
        if_req = 1; if_addr = 32'h400; mem_ready = 1;
        if_rdata_at_dm_rv = 32'hFFFF_FFFF; dm_rdata_at_if_rv = 32'hFFFF_FFFF;
        run_auto(12);
        check("ld_dm_rv_cnt",   n_dm_rv, 1);
        check("ld_if_rv_cnt",   n_if_rv, 1);
        check("ld_first_is_d",  gseq[1:0], 2'b10);
        check("ld_if_hold",     if_rdata_at_dm_rv, 32'h00500093);
        check("ld_dm_hold",     dm_rdata_at_if_rv, 32'h12345678);
        check("ld_dm_rdata",    dm_rdata, 32'h12345678);
        check("ld_if_rdata",    if_rdata, 32'hAAAA5555);

        // Spurious mem_rvalid in IDLE.
        tick(); mem_rvalid = 1; mem_rdata = 32'hBAD0_0000;
        tick(); mem_rvalid = 0; mem_rdata = 0;
        @(negedge clk);
        check("sp_idle_ifrv", if_rvalid, 0);
        check("sp_idle_dmrv", dm_rvalid, 0);
        check("sp_idle_busy", busy, 0);
        // Spurious mem_rvalid in REQ (memory not ready).
        tick(); if_req = 1; if_addr = 32'h700; mem_ready = 0;
        @(negedge clk);
        check("sp_req_gnt", if_gnt, 1);
        tick(); if_req = 0; mem_rvalid = 1; mem_rdata = 32'hBAD1_1111;
        @(negedge clk);
        check("sp_req_memreq", mem_req, 1);
        tick(); mem_rvalid = 0; mem_rdata = 0;
        @(negedge clk);
        check("sp_req_ifrv",  if_rvalid, 0);
        check("sp_req_dmrv",  dm_rvalid, 0);
        check("sp_req_still", mem_req, 1);
        check("sp_req_ifrd",  if_rdata, 32'hAAAA5555);
        check("sp_req_dmrd",  dm_rdata, 32'h12345678);

        // Starvation bound: both requests held, data as stores.
        do_reset();
        tick(); hold_if = 1; hold_dm = 1; mem_ready = 1;
        if_req = 1; if_addr = 32'h500;
        dm_req = 1; dm_we = 1; dm_be = 4'b1111; dm_addr = 32'h600; dm_wdata = 32'h1;
        run_auto(40);
        check("sv_enough",  (n_gnt >= 10), 1);
        check("sv_order",   gseq, 10'b10000_10000);
        check("sv_no_dual", n_dual, 0);
        do_reset();

        // Reset asserted while waiting in RESP, stray mem_rvalid after release.
        tick(); if_req = 1; if_addr = 32'h800; mem_ready = 1;
        @(negedge clk);
        check("r_gnt", if_gnt, 1);
        tick(); if_req = 0;
        tick();
        #2 reset = 0;
        #1;
        check("r_busy",    busy, 0);
        check("r_memreq",  mem_req, 0);
        check("r_memaddr", mem_addr, 0);
        check("r_membe",   mem_be, 0);
        @(negedge clk);
        reset = 1;
        tick(); mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("r_busy_idle", busy, 0);
        tick(); mem_rvalid = 0; mem_rdata = 0;
        @(negedge clk);
        check("r_ifrv", if_rvalid, 0);
        check("r_dmrv", dm_rvalid, 0);
        check("r_ifrd", if_rdata, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
